data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It is the slave end of the load/store interface the single-cycle RISC-V datapath drives through ALU_Out, rs2 data, MemRead/MemWrite and funct3.
- It accepts one request at a time over a valid/ready handshake and performs byte/halfword/word access with RISC-V sign/zero extension.
- It returns the result after a fixed latency, holding it until the initiator consumes it.
- It replaces the combinational Data_Memory in the planned multi-cycle datapath.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from the accepting edge to rsp_valid high; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator consumes the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; latency counter=0.
  - All memory words are cleared to 0.
  - Reset mid-operation aborts the request; the store is not committed and no response is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Accept on a rising edge with req_valid=1 (req_ready=1).
  - Latch req_write, req_addr, req_wdata and req_funct3; input changes after acceptance are ignored.
  - If LATENCY=1, go to RESP; otherwise load counter=LATENCY-1 and go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - On the edge where counter==1, execute the access and go to RESP.
  - req_ready=0 throughout.
- Execute step (a single edge; memory is written here):
  - Word index = addr[31:2]. Out of range if the index >= DEPTH_WORDS.
  - Loads: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend halfword addr[1]; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend; any other value is an error.
  - Stores: 000 SB writes only byte lane addr[1:0]; 001 SH writes halfword lane addr[1]; 010 SW writes the full word; any other value is an error. Unwritten lanes are preserved.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) is an error.
  - On error: rsp_err=1, rsp_rdata=0, memory unchanged.
  - Little-endian: byte lane 0 = bits 7:0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE.
  - A new request can be accepted on the following edge at the earliest.
  - Throughput is one access per LATENCY+1 cycles minimum.
- rsp_ready held low stalls indefinitely in RESP with no state change.
- req_valid arriving while busy is not accepted; the initiator must hold it until req_ready is high.
- Store response: rsp_valid pulses as in the load case, with rsp_rdata=0 and rsp_err=0 on success.
- No combinational path from the req_* inputs to the rsp_* outputs; all outputs are registered.

Test Plan:
- Reset then LW addr 0x00 (LATENCY=2) -> req_ready drops next cycle; rsp_valid high exactly 2 cycles after the accepting edge; rsp_rdata=0x00000000; rsp_err=0.
- SW 0x80FF7F01 to 0x10, then LB/LBU/LH/LHU at 0x10, 0x11, 0x12 -> LB@0x10=0x00000001, LB@0x11=0x0000007F, LBU@0x12=0x000000FF, LB@0x12=0xFFFFFFFF, LH@0x12=0xFFFF80FF, LHU@0x12=0x000080FF.
- SB 0xAA to 0x21 over a prior SW 0x11223344 at 0x20 -> LW 0x20 returns 0x1122AA44; then SH 0xBEEF at 0x22 -> LW returns 0xBEEFAA44.
- Errors: LW at 0x06, SH at 0x03, SW at 0x400 (DEPTH_WORDS=256), funct3=011 -> rsp_err=1, rsp_rdata=0; a following LW of each affected aligned word shows the memory unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_valid and rsp_rdata stable; req_ready=0; no second accept; after rsp_ready=1, the next request is accepted one edge later.
- Assert rst during BUSY of SW 0xDEADBEEF at 0x30 -> outputs return to reset values immediately; a later LW 0x30 returns 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder with a fixed-latency valid/ready handshake
// and RISC-V byte/halfword/word access with sign/zero extension.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0]  count;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_funct3;

  logic        accept, execute;
  logic        ex_write;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_funct3;
  logic        oob, misalign, illegal, err, wr_en;
  logic [31:0] ex_word, new_word, rdata;
  logic [7:0]  ex_byte;
  logic [15:0] ex_half;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;
  assign execute   = (accept && LATENCY == 1) || (state == BUSY && count == 4'd1);

  // With LATENCY=1 the access executes on the accepting edge, straight from the inputs.
  always_comb begin
    ex_write  = lat_write;
    ex_addr   = lat_addr;
    ex_wdata  = lat_wdata;
    ex_funct3 = lat_funct3;
    if (state == IDLE) begin
      ex_write  = req_write;
      ex_addr   = req_addr;
      ex_wdata  = req_wdata;
      ex_funct3 = req_funct3;
    end
  end

  assign oob     = 32'(ex_addr[31:2]) >= 32'(DEPTH_WORDS);
  assign ex_word = oob ? 32'd0 : mem[ex_addr[IW+1:2]];
  assign ex_byte = ex_word[{ex_addr[1:0], 3'b000} +: 8];
  assign ex_half = ex_addr[1] ? ex_word[31:16] : ex_word[15:0];

  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    rdata    = 32'd0;
    new_word = ex_word;
    if (ex_write) begin
      case (ex_funct3)
        3'b000: new_word[{ex_addr[1:0], 3'b000} +: 8] = ex_wdata[7:0];
        3'b001: begin
          misalign = ex_addr[0];
          new_word[{ex_addr[1], 4'b0000} +: 16] = ex_wdata[15:0];
        end
        3'b010: begin
          misalign = |ex_addr[1:0];
          new_word = ex_wdata;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (ex_funct3)
        3'b000: rdata = {{24{ex_byte[7]}}, ex_byte};
        3'b001: begin
          misalign = ex_addr[0];
          rdata    = {{16{ex_half[15]}}, ex_half};
        end
        3'b010: begin
          misalign = |ex_addr[1:0];
          rdata    = ex_word;
        end
        3'b100: rdata = {24'd0, ex_byte};
        3'b101: begin
          misalign = ex_addr[0];
          rdata    = {16'd0, ex_half};
        end
        default: illegal = 1'b1;
      endcase
    end
    err   = oob | misalign | illegal;
    wr_en = ex_write && !err;
    if (err || ex_write) rdata = 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (count == 4'd1) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      if (accept) begin
        lat_write  <= req_write;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
        count      <= 4'(LATENCY - 1);
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if (execute) begin
        rsp_rdata <= rdata;
        rsp_err   <= err;
        if (wr_en) mem[ex_addr[IW+1:2]] <= new_word;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, errors, stall and reset abort.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every consumed response is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic expect_rsp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    q.push_back(e);
  endtask

  // Present a request, wait for acceptance, then scramble the inputs to prove they were latched.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w; req_addr = 32'hFFFF_FFFF; req_wdata = $urandom; req_funct3 = 3'b111;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                      input logic [31:0] rd, input logic er);
    expect_rsp(rd, er);
    issue(w, a, d, f3);
    wait_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'd0; rsp_ready = 1'b1;
    #12;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: low one cycle after acceptance, high at the second edge's sample point.
    expect_rsp(32'd0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, LW);
    chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lat_cycle1_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_rdata", rsp_rdata, 32'd0);

    // Sub-word loads with sign/zero extension.
    xact(1'b1, 32'h10, 32'h80FF7F01, SW, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, LB,  32'h00000001, 1'b0);
    xact(1'b0, 32'h11, 32'h0, LB,  32'h0000007F, 1'b0);
    xact(1'b0, 32'h12, 32'h0, LBU, 32'h000000FF, 1'b0);
    xact(1'b0, 32'h12, 32'h0, LB,  32'hFFFFFFFF, 1'b0);
    xact(1'b0, 32'h12, 32'h0, LH,  32'hFFFF80FF, 1'b0);
    xact(1'b0, 32'h12, 32'h0, LHU, 32'h000080FF, 1'b0);
    xact(1'b0, 32'h13, 32'h0, LBU, 32'h00000080, 1'b0);

    // Partial stores preserve untouched lanes.
    xact(1'b1, 32'h20, 32'h11223344, SW, 32'h0, 1'b0);
    xact(1'b1, 32'h21, 32'h555555AA, SB, 32'h0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, LW, 32'h1122AA44, 1'b0);
    xact(1'b1, 32'h22, 32'h1234BEEF, SH, 32'h0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, LW, 32'hBEEFAA44, 1'b0);

    // Error cases leave memory untouched.
    xact(1'b1, 32'h04, 32'hCAFEF00D, SW, 32'h0, 1'b0);
    xact(1'b0, 32'h06, 32'h0, LW, 32'h0, 1'b1);
    xact(1'b1, 32'h03, 32'h00001234, SH, 32'h0, 1'b1);
    xact(1'b0, 32'h00, 32'h0, LW, 32'h0, 1'b0);
    xact(1'b1, 32'h400, 32'h12345678, SW, 32'h0, 1'b1);
    xact(1'b0, 32'h400, 32'h0, LW, 32'h0, 1'b1);
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, LW, 32'h80FF7F01, 1'b0);
    xact(1'b0, 32'h04, 32'h0, LW, 32'hCAFEF00D, 1'b0);

    // Stall in RESP with a second request pending.
    rsp_ready = 1'b0;
    expect_rsp(32'hBEEFAA44, 1'b0);
    expect_rsp(32'h80FF7F01, 1'b0);
    issue(1'b0, 32'h20, 32'h0, LW);
    req_write = 1'b0; req_addr = 32'h10; req_funct3 = LW; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    held = rsp_rdata;
    chk("stall_rdata_value", held, 32'hBEEFAA44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, held);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("second_accept", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_rsp();

    // Reset during BUSY aborts the store.
    issue(1'b1, 32'h30, 32'hDEADBEEF, SW);
    rst = 1'b1;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h30, 32'h0, LW, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
